snake_game_ctrl: RTL and testbench

Game sequencer for the 8x8 LED snake. It owns the game state machine, the move-rate tick, direction arbitration with reversal rejection, wall-collision prediction, and length and score bookkeeping. It issues one step command per move tick to the snake body/framebuffer datapath through a valid/ready handshake, then waits for that datapath's step response. It sits between the button inputs and the body datapath, replacing the free-running move clock.

---
 rtl/snake_game_ctrl_pkg.sv | 29 ++
 rtl/snake_game_ctrl_if.sv | 23 ++
 rtl/snake_game_ctrl_tick_gen.sv | 36 +++
 rtl/snake_game_ctrl.sv | 176 +++++++++++++++++
 tb/tb_snake_game_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/snake_game_ctrl_pkg.sv
// Shared types and default geometry for the snake game sequencer.
package snake_pkg;

    typedef enum logic [1:0] {
        LEFT  = 2'b00,
        DOWN  = 2'b01,
        UP    = 2'b10,
        RIGHT = 2'b11
    } dir_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        OVER  = 3'd4,
        WIN   = 3'd5
    } state_t;

    localparam int GRID     = 8;
    localparam int INIT_LEN = 3;
    localparam int MAX_LEN  = 64;

    // Opposite directions differ in both encoding bits.
    function automatic logic is_reverse(dir_t a, dir_t b);
        return (a ^ b) == 2'b11;
    endfunction

endpackage

// File: rtl/snake_game_ctrl_if.sv
// Step command / step response link between the sequencer and the body datapath.
interface snake_game_ctrl_if;
    import snake_pkg::*;

    logic step_valid;
    logic step_ready;
    dir_t step_dir;
    logic step_grow;
    logic resp_valid;
    logic resp_hit_self;
    logic resp_ate;

    modport master (
        output step_valid, step_dir, step_grow,
        input  step_ready, resp_valid, resp_hit_self, resp_ate
    );

    modport slave (
        input  step_valid, step_dir, step_grow,
        output step_ready, resp_valid, resp_hit_self, resp_ate
    );

endinterface

// File: rtl/snake_game_ctrl_tick_gen.sv
// Divide-by-DIV tick generator with enable and synchronous restart.
module snake_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: move tick, direction arbitration, wall prediction,
// step handshake to the body datapath, and length/score bookkeeping.
module snake_game_ctrl #(
    parameter int TICK_DIV = 10000000,
    parameter int GRID     = snake_pkg::GRID,
    parameter int INIT_LEN = snake_pkg::INIT_LEN,
    parameter int MAX_LEN  = snake_pkg::MAX_LEN
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              start,
    input  logic [3:0]        direction,
    input  logic [2:0]        head_x,
    input  logic [2:0]        head_y,
    output logic              init,
    snake_game_ctrl_if.master bus,
    output logic [2:0]        state,
    output logic              game_over,
    output logic              won,
    output logic [6:0]        score,
    output logic [6:0]        length
);
    import snake_pkg::*;

    state_t     state_q, state_d;
    dir_t       dir_q, dir_d, pend_q, pend_d, cand;
    logic       valid_q, valid_d, grow_q, grow_d;
    logic       gpend_q, gpend_d, over_q, won_q;
    logic [6:0] score_q, score_d, len_q, len_d;
    logic [3:0] btn_ok;
    logic [3:0] nx, ny;
    logic       active, restart, tick, wall, cand_v;

    assign active  = (state_q == RUN) || (state_q == ISSUE) || (state_q == WAIT);
    assign restart = start &&
                     ((state_q == IDLE) || (state_q == OVER) || (state_q == WIN));

    snake_tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .rst    (clear),
        .en_i   (active),
        .clr_i  (restart),
        .tick_o (tick)
    );

    // Reversals are masked first so a lower-priority button can still win.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            btn_ok[i] = direction[i] && !is_reverse(dir_t'(2'(i)), dir_q);
        end
        cand   = RIGHT;
        cand_v = 1'b1;
        priority case (1'b1)
            btn_ok[3]: cand = RIGHT;
            btn_ok[0]: cand = LEFT;
            btn_ok[1]: cand = DOWN;
            btn_ok[2]: cand = UP;
            default:   cand_v = 1'b0;
        endcase
    end

    always_comb begin
        nx   = {1'b0, head_x};
        ny   = {1'b0, head_y};
        wall = 1'b0;
        unique case (pend_q)
            RIGHT:   wall = (nx + 4'd1) > 4'(GRID - 1);
            LEFT:    wall = (nx == 4'd0);
            DOWN:    wall = (ny + 4'd1) > 4'(GRID - 1);
            UP:      wall = (ny == 4'd0);
            default: wall = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        pend_d  = pend_q;
        valid_d = valid_q;
        grow_d  = grow_q;
        gpend_d = gpend_q;
        score_d = score_q;
        len_d   = len_q;
        if (active && cand_v) begin
            pend_d = cand;
        end
        unique case (state_q)
            IDLE, OVER, WIN: begin
                if (start) begin
                    state_d = RUN;
                    score_d = '0;
                    len_d   = 7'(INIT_LEN);
                    dir_d   = RIGHT;
                    pend_d  = RIGHT;
                    gpend_d = 1'b0;
                end
            end
            RUN: begin
                if (tick) begin
                    if (wall) begin
                        state_d = OVER;
                    end else begin
                        dir_d   = pend_q;
                        grow_d  = gpend_q;
                        valid_d = 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (bus.step_ready) begin
                    valid_d = 1'b0;
                    gpend_d = 1'b0;
                    grow_d  = 1'b0;
                    if (grow_q) begin
                        len_d = len_q + 7'd1;
                    end
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.resp_valid) begin
                    if (bus.resp_hit_self) begin
                        state_d = OVER;
                    end else if (len_q == 7'(MAX_LEN)) begin
                        state_d = WIN;
                    end else begin
                        if (bus.resp_ate) begin
                            score_d = (score_q == 7'd127) ? score_q : score_q + 7'd1;
                            gpend_d = 1'b1;
                        end
                        state_d = RUN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
            dir_q   <= RIGHT;
            pend_q  <= RIGHT;
            valid_q <= 1'b0;
            grow_q  <= 1'b0;
            gpend_q <= 1'b0;
            score_q <= '0;
            len_q   <= 7'(INIT_LEN);
            over_q  <= 1'b0;
            won_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
            valid_q <= valid_d;
            grow_q  <= grow_d;
            gpend_q <= gpend_d;
            score_q <= score_d;
            len_q   <= len_d;
            over_q  <= (state_d == OVER);
            won_q   <= (state_d == WIN);
        end
    end

    assign init           = restart;
    assign bus.step_valid = valid_q;
    assign bus.step_dir   = dir_q;
    assign bus.step_grow  = grow_q;
    assign state          = state_q;
    assign game_over      = over_q;
    assign won            = won_q;
    assign score          = score_q;
    assign length         = len_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Bench for snake_game_ctrl: directed vector table, corner sequences, random vs model.
module tb_snake_game_ctrl;

    localparam int TDIV = 4;
    localparam int MAXL = 5;

    logic       clk = 1'b0;
    logic       clear;
    logic       start;
    logic [3:0] direction;
    logic [2:0] head_x, head_y;
    logic       init, game_over, won;
    logic [2:0] state;
    logic [6:0] score, length;

    snake_game_ctrl_if bus();

    snake_game_ctrl #(
        .TICK_DIV (TDIV),
        .GRID     (8),
        .INIT_LEN (3),
        .MAX_LEN  (MAXL)
    ) dut (
        .clk       (clk),
        .clear     (clear),
        .start     (start),
        .direction (direction),
        .head_x    (head_x),
        .head_y    (head_y),
        .init      (init),
        .bus       (bus),
        .state     (state),
        .game_over (game_over),
        .won       (won),
        .score     (score),
        .length    (length)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       v;
        logic [1:0] d;
        logic       g;
        logic [6:0] sc;
        logic [6:0] ln;
        logic       ini;
        logic       go;
        logic       wn;
    } obs_t;

    typedef struct {
        int         reps;
        bit         s;
        logic [3:0] b;
        bit         rdy, rv, hit, ate;
        obs_t       exp;
    } vec_t;

    int total  = 0;
    int passed = 0;
    vec_t tbl[$];

    int m_st, m_cnt, m_dir, m_pend, m_score, m_len;
    bit m_valid, m_grow, m_gp;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    function automatic obs_t mk_obs(int st, bit v, int d, bit g, int sc, int ln, bit ini);
        obs_t o;
        o.st  = 3'(st);
        o.v   = v;
        o.d   = 2'(d);
        o.g   = g;
        o.sc  = 7'(sc);
        o.ln  = 7'(ln);
        o.ini = ini;
        o.go  = (st == 4);
        o.wn  = (st == 5);
        return o;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.st  = state;
        o.v   = bus.step_valid;
        o.d   = bus.step_dir;
        o.g   = bus.step_grow;
        o.sc  = score;
        o.ln  = length;
        o.ini = init;
        o.go  = game_over;
        o.wn  = won;
        return o;
    endfunction

    function automatic vec_t mkv(int reps, bit s, logic [3:0] b, bit rdy, bit rv,
                                 bit hit, bit ate, obs_t e);
        vec_t t;
        t.reps = reps; t.s = s; t.b = b; t.rdy = rdy;
        t.rv = rv; t.hit = hit; t.ate = ate; t.exp = e;
        return t;
    endfunction

    task automatic drive(bit s, logic [3:0] b, bit rdy, bit rv, bit hit, bit ate);
        start             = s;
        direction         = b;
        bus.step_ready    = rdy;
        bus.resp_valid    = rv;
        bus.resp_hit_self = hit;
        bus.resp_ate      = ate;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(string nm, int budget);
        int n = 0;
        while (bus.step_valid !== 1'b1 && n < budget) begin
            next_cyc();
            n++;
        end
        chk(nm, bus.step_valid, 1);
    endtask

    // Game-level reference: a move tick every TDIV active cycles, grid walls,
    // and the step/response rules applied to plain integer state.
    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_dir = 3; m_pend = 3;
        m_score = 0; m_len = 3; m_valid = 0; m_grow = 0; m_gp = 0;
    endtask

    function automatic obs_t model_obs();
        return mk_obs(m_st, m_valid, m_dir, m_grow, m_score, m_len,
                      start && (m_st == 0 || m_st == 4 || m_st == 5));
    endfunction

    task automatic model_step();
        int prio[4] = '{3, 0, 1, 2};
        bit act  = (m_st >= 1 && m_st <= 3);
        bit idle = (m_st == 0 || m_st == 4 || m_st == 5);
        bit tk   = act && (m_cnt == TDIV - 1);
        bit got  = 0;
        int st = m_st, cnt = m_cnt, dir = m_dir, pend = m_pend;
        int sc = m_score, ln = m_len;
        bit v = m_valid, g = m_grow, gp = m_gp;
        int x, y;
        if (act) begin
            cnt = (m_cnt + 1) % TDIV;
            for (int k = 0; k < 4; k++) begin
                if (!got && direction[prio[k]] && (prio[k] + m_dir != 3)) begin
                    pend = prio[k];
                    got  = 1;
                end
            end
        end
        if (idle && start) begin
            st = 1; cnt = 0; sc = 0; ln = 3; dir = 3; pend = 3; gp = 0;
        end else if (m_st == 1 && tk) begin
            x = int'(head_x);
            y = int'(head_y);
            case (m_pend)
                0: x = x - 1;
                1: y = y + 1;
                2: y = y - 1;
                default: x = x + 1;
            endcase
            if (x < 0 || x > 7 || y < 0 || y > 7) st = 4;
            else begin
                dir = m_pend; g = m_gp; v = 1; st = 2;
            end
        end else if (m_st == 2 && bus.step_ready) begin
            v = 0; gp = 0; g = 0; st = 3;
            if (m_grow) ln = m_len + 1;
        end else if (m_st == 3 && bus.resp_valid) begin
            if (bus.resp_hit_self) st = 4;
            else if (m_len == MAXL) st = 5;
            else begin
                if (bus.resp_ate) begin
                    sc = (m_score < 127) ? m_score + 1 : 127;
                    gp = 1;
                end
                st = 1;
            end
        end
        m_st = st; m_cnt = cnt; m_dir = dir; m_pend = pend;
        m_score = sc; m_len = ln; m_valid = v; m_grow = g; m_gp = gp;
    endtask

    initial begin
        bit seen;
        clear  = 1'b1;
        head_x = 3'd3;
        head_y = 3'd3;
        drive(0, 4'b0000, 0, 0, 0, 0);

        //           reps s  btn   rdy rv hit ate        st v d g sc ln init
        tbl.push_back(mkv(1,  0, 4'b0000, 0, 0, 0, 0, mk_obs(0, 0, 3, 0, 0, 3, 0)));
        tbl.push_back(mkv(1,  1, 4'b0000, 0, 0, 0, 0, mk_obs(0, 0, 3, 0, 0, 3, 1)));
        tbl.push_back(mkv(4,  0, 4'b0000, 0, 0, 0, 0, mk_obs(1, 0, 3, 0, 0, 3, 0)));
        tbl.push_back(mkv(5,  0, 4'b0001, 0, 0, 0, 0, mk_obs(2, 1, 3, 0, 0, 3, 0)));
        tbl.push_back(mkv(5,  0, 4'b0000, 0, 1, 1, 1, mk_obs(2, 1, 3, 0, 0, 3, 0)));
        tbl.push_back(mkv(1,  0, 4'b0000, 1, 0, 0, 0, mk_obs(2, 1, 3, 0, 0, 3, 0)));
        tbl.push_back(mkv(1,  0, 4'b0000, 0, 0, 0, 0, mk_obs(3, 0, 3, 0, 0, 3, 0)));
        tbl.push_back(mkv(1,  0, 4'b0000, 0, 1, 0, 0, mk_obs(3, 0, 3, 0, 0, 3, 0)));
        tbl.push_back(mkv(3,  0, 4'b0011, 0, 0, 0, 0, mk_obs(1, 0, 3, 0, 0, 3, 0)));
        tbl.push_back(mkv(1,  0, 4'b0000, 1, 0, 0, 0, mk_obs(2, 1, 1, 0, 0, 3, 0)));
        tbl.push_back(mkv(1,  0, 4'b0000, 0, 1, 0, 1, mk_obs(3, 0, 1, 0, 0, 3, 0)));
        tbl.push_back(mkv(2,  0, 4'b0000, 0, 0, 0, 0, mk_obs(1, 0, 1, 0, 1, 3, 0)));
        tbl.push_back(mkv(1,  0, 4'b0000, 1, 0, 0, 0, mk_obs(2, 1, 1, 1, 1, 3, 0)));
        tbl.push_back(mkv(1,  0, 4'b0000, 0, 1, 0, 1, mk_obs(3, 0, 1, 0, 1, 4, 0)));
        tbl.push_back(mkv(2,  0, 4'b0000, 0, 0, 0, 0, mk_obs(1, 0, 1, 0, 2, 4, 0)));
        tbl.push_back(mkv(1,  0, 4'b0000, 1, 0, 0, 0, mk_obs(2, 1, 1, 1, 2, 4, 0)));
        tbl.push_back(mkv(1,  0, 4'b0000, 0, 1, 0, 0, mk_obs(3, 0, 1, 0, 2, 5, 0)));
        tbl.push_back(mkv(1,  0, 4'b0000, 0, 0, 0, 0, mk_obs(5, 0, 1, 0, 2, 5, 0)));
        tbl.push_back(mkv(1,  1, 4'b0000, 0, 0, 0, 0, mk_obs(5, 0, 1, 0, 2, 5, 1)));
        tbl.push_back(mkv(1,  0, 4'b0000, 0, 0, 0, 0, mk_obs(1, 0, 3, 0, 0, 3, 0)));

        @(posedge clk);
        @(posedge clk);
        #1;
        clear = 1'b0;

        foreach (tbl[i]) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                drive(tbl[i].s, tbl[i].b, tbl[i].rdy, tbl[i].rv, tbl[i].hit, tbl[i].ate);
                #1;
                chk($sformatf("vec%0d.%0d", i, r), dut_obs(), tbl[i].exp);
                next_cyc();
            end
        end

        // Eat once, then a self hit that also lands on food.
        drive(0, 4'b0000, 0, 0, 0, 0);
        wait_valid("a_step1", 8);
        drive(0, 4'b0000, 1, 0, 0, 0); next_cyc(); drive(0, 4'b0000, 0, 0, 0, 0);
        chk("a_wait", state, 3);
        drive(0, 4'b0000, 0, 1, 0, 1); next_cyc(); drive(0, 4'b0000, 0, 0, 0, 0);
        chk("a_ate", {state, score}, {3'd1, 7'd1});
        wait_valid("a_step2", 8);
        chk("a_grow", bus.step_grow, 1);
        drive(0, 4'b0000, 1, 0, 0, 0); next_cyc(); drive(0, 4'b0000, 0, 0, 0, 0);
        chk("a_len", {length, bus.step_grow}, {7'd4, 1'b0});
        drive(0, 4'b0000, 0, 1, 1, 1); next_cyc(); drive(0, 4'b0000, 0, 0, 0, 0);
        chk("a_hit_over", {state, game_over, score}, {3'd4, 1'b1, 7'd1});

        // Right wall at x=7.
        head_x = 3'd7; head_y = 3'd3;
        drive(1, 4'b0000, 0, 0, 0, 0); next_cyc(); drive(0, 4'b0000, 0, 0, 0, 0);
        seen = 0;
        repeat (6) begin seen |= bus.step_valid; next_cyc(); end
        chk("b_wall_nostep", seen, 0);
        chk("b_wall_over", {state, game_over}, {3'd4, 1'b1});
        chk("b_restart_clr", {score, length}, {7'd0, 7'd3});

        // Top wall at y=0 after turning up.
        head_x = 3'd3; head_y = 3'd0;
        drive(1, 4'b0000, 0, 0, 0, 0); next_cyc();
        drive(0, 4'b0100, 0, 0, 0, 0); next_cyc();
        drive(0, 4'b0000, 0, 0, 0, 0);
        seen = 0;
        repeat (6) begin seen |= bus.step_valid; next_cyc(); end
        chk("c_wall_nostep", seen, 0);
        chk("c_wall_over", {state, game_over}, {3'd4, 1'b1});

        // Last legal column still steps; then clear lands mid-ISSUE.
        head_x = 3'd6; head_y = 3'd3;
        drive(1, 4'b0000, 0, 0, 0, 0); next_cyc(); drive(0, 4'b0000, 0, 0, 0, 0);
        wait_valid("d_edge_step", 8);
        chk("d_dir", bus.step_dir, 3);
        #2;
        clear = 1'b1;
        #1;
        chk("d_clear_async", dut_obs(), mk_obs(0, 0, 3, 0, 0, 3, 0));
        next_cyc();
        clear = 1'b0;
        model_reset();

        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 99) < 3,
                  ($urandom_range(0, 99) < 30) ? 4'($urandom) : 4'b0000,
                  1'($urandom_range(0, 1)),
                  $urandom_range(0, 9) < 4,
                  $urandom_range(0, 19) == 0,
                  1'($urandom_range(0, 1)));
            case ($urandom_range(0, 3))
                0: head_x = 3'd0;
                1: head_x = 3'd7;
                default: head_x = 3'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0: head_y = 3'd0;
                1: head_y = 3'd7;
                default: head_y = 3'($urandom);
            endcase
            #1;
            chk($sformatf("rand%0d", c), dut_obs(), model_obs());
            model_step();
            next_cyc();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
